i2cmb_xfer_engine: RTL and testbench
====================================

// Module: i2cmb_xfer_engine
// PURPOSE
//  Hardware Wishbone master that turns one I2C transfer request (bus, address, direction, length) into
//  the IICMB register sequence (CSR/DPR/CMDR) and streams write/read bytes. Sits between a
//  system-side request/stream interface and the iicmb_m_wb slave port.
//  Multi-bus successor of the single-bus driver flow: any of NUM_BUSSES buses, caches the selected bus.
// PARAMETERS
//  NUM_BUSSES     16    I2C buses behind the controller; req_bus legal range 0..NUM_BUSSES-1
//  WB_ADDR_WIDTH  2     Wishbone address width (CSR=0, DPR=1, CMDR=2, FSMR=3)
//  WB_DATA_WIDTH  8     Wishbone data width
//  MAX_LEN        32    max bytes per transfer; LW = $clog2(MAX_LEN+1)
//  POLL_GAP       4     idle cycles between CMDR polls
//  TIMEOUT_CYC    65535 cycles allowed per command completion before abort
// PORTS
//  clk_i        in   1      clock
//  rst_n_i      in   1      async active-low reset
//  req_valid_i  in   1      transfer request valid
//  req_ready_o  out  1      engine idle, request accepted on valid&ready
//  req_bus_i    in   8      target bus index
//  req_addr_i   in   7      7-bit I2C slave address
//  req_rd_i     in   1      1=read, 0=write
//  req_len_i    in   LW     byte count (0 = address-only probe)
//  wdata_valid_i/wdata_ready_o/wdata_i  in/out/in  1/1/8  write byte stream
//  rdata_valid_o/rdata_ready_i/rdata_o  out/in/out 1/1/8  read byte stream
//  done_o       out  1      1-cycle pulse at end of transfer
//  status_o     out  3      0 OK,1 NAK,2 ARB_LOST,3 ERR,4 TIMEOUT; valid with done_o, held after
//  cyc_o stb_o we_o  out 1  Wishbone master strobes
//  adr_o        out  WB_ADDR_WIDTH; dat_o out WB_DATA_WIDTH; dat_i in WB_DATA_WIDTH; ack_i in 1; irq_i in 1
// BEHAVIOUR
//  Reset: all outputs 0; bus cache invalid; FSM=INIT. Assert mid-transfer: cyc/stb drop at once, no Stop;
//   after release engine re-runs INIT.
//  WB access: drive cyc/stb/we/adr/dat together, hold until ack_i; drop next cycle; >=1 idle cycle between
//   accesses. Reads capture dat_i on ack cycle.
//  INIT: write CSR=0x80 (enable) -> IDLE. req_ready_o=1 only in IDLE.
//  Accept: if req_bus_i>=NUM_BUSSES -> done_o, status ERR, zero WB traffic.
//  SETBUS (skipped if req_bus equals cached bus): DPR=bus, CMDR=0x06, WAIT.
//  START: CMDR=0x04, WAIT. ADDR: DPR={addr,rd}, CMDR=0x01, WAIT.
//  Write loop (len times): stall with wdata_ready_o=1 until wdata_valid_i; DPR=byte, CMDR=0x01, WAIT.
//  Read loop: CMDR=0x02 (ack) or 0x03 (nak) for last byte, WAIT, read DPR, present on rdata_o with
//   rdata_valid_o held until rdata_ready_i; next command only after handshake.
//  STOP: CMDR=0x05, WAIT -> DONE (done_o pulse) -> IDLE.
//  WAIT: read CMDR every POLL_GAP idle cycles; DON(b7)->continue; NAK(b6)->STOP then status NAK;
//   AL(b5)->skip STOP, status ARB_LOST, invalidate bus cache; ERR(b4)->status ERR, invalidate cache;
//   no completion within TIMEOUT_CYC -> status TIMEOUT, skip STOP, re-run INIT.
//  Byte counter LW bits, counts down, never wraps; len=0 goes ADDR->STOP.
//  Write data never times out; read stall never times out (only the WAIT timer runs).
// CONFIGURATION
//  IRQ_WAIT_EN defined: INIT writes CSR=0xC0; WAIT idles until irq_i=1 then reads CMDR once
//   (clears irq); TIMEOUT still applies. Undefined: CSR=0x80, polling as above; irq_i ignored.
// TESTING
//  Write bus 3, addr 0x22, len 2, bytes A5,5A -> WB writes DPR=03,CMDR=06,CMDR=04,DPR=44,CMDR=01,
//   DPR=A5,CMDR=01,DPR=5A,CMDR=01,CMDR=05; status 0.
//  Read bus 3 again, addr 0x22, len 3 -> no SetBus; DPR=45; CMDR 02,02,03; 3 bytes out; status 0.
//  Addr NAK (CMDR returns 0x40) -> Stop issued, no data bytes, status 1.
//  req_bus=NUM_BUSSES -> done_o next cycles, status 3, cyc_o never asserted.
//  ack_i stuck/CMDR never DON -> status 4 after TIMEOUT_CYC, then CSR=0x80 rewritten.
//  rst_n_i low mid-read with rdata_ready_i=0 -> all outputs 0 immediately; after release first access CSR write.

Source files
------------

// File: rtl/i2cmb_xfer_engine.sv
`default_nettype none
// ============================================================================
//  Module   : i2cmb_xfer_engine
//  Purpose  : Wishbone master that sequences IICMB CSR/DPR/CMDR accesses for
//             one I2C transfer request (bus select, address, data bytes).
//  Option   : IRQ_WAIT_EN - wait for irq_i instead of timed CMDR polling
//  Revision : 1.0 - initial release
// ============================================================================
module i2cmb_xfer_engine #(
    parameter int NUM_BUSSES    = 16,
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8,
    parameter int MAX_LEN       = 32,
    parameter int POLL_GAP      = 4,
    parameter int TIMEOUT_CYC   = 65535,
    localparam int LW           = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [7:0]               req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic                     req_rd_i,
    input  logic [LW-1:0]            req_len_i,
    input  logic                     wdata_valid_i,
    output logic                     wdata_ready_o,
    input  logic [7:0]               wdata_i,
    output logic                     rdata_valid_o,
    input  logic                     rdata_ready_i,
    output logic [7:0]               rdata_o,
    output logic                     done_o,
    output logic [2:0]               status_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int c_tw = $clog2(TIMEOUT_CYC + 1);
    localparam int c_gw = $clog2(POLL_GAP + 1);

    localparam logic [c_tw-1:0] c_tmo      = c_tw'(TIMEOUT_CYC);
    localparam logic [c_gw-1:0] c_gap_last = c_gw'(POLL_GAP - 1);
    localparam logic [8:0]      c_nbus     = 9'(NUM_BUSSES);

    localparam logic [WB_ADDR_WIDTH-1:0] c_adr_csr  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] c_adr_dpr  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] c_adr_cmdr = WB_ADDR_WIDTH'(2);

`ifdef IRQ_WAIT_EN
    localparam logic [WB_DATA_WIDTH-1:0] c_csr_en = WB_DATA_WIDTH'(8'hC0);
`else
    localparam logic [WB_DATA_WIDTH-1:0] c_csr_en = WB_DATA_WIDTH'(8'h80);
`endif

    localparam logic [2:0] c_st_ok  = 3'd0;
    localparam logic [2:0] c_st_nak = 3'd1;
    localparam logic [2:0] c_st_al  = 3'd2;
    localparam logic [2:0] c_st_err = 3'd3;
    localparam logic [2:0] c_st_tmo = 3'd4;

    typedef enum logic [4:0] {
        S_INIT, S_IDLE, S_SETBUS, S_SETBUS_CMD, S_SETBUS_OK, S_START, S_ADDR,
        S_ADDR_CMD, S_XFER, S_WR_DATA, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_RD_OUT,
        S_STOP, S_BUS, S_GAP, S_WAIT, S_EVAL, S_DONE
    } state_t;

    state_t                   r_state, w_state, r_ret, w_ret, r_cont, w_cont;
    logic                     r_we, w_we;
    logic [WB_ADDR_WIDTH-1:0] r_adr, w_adr;
    logic [WB_DATA_WIDTH-1:0] r_dat, w_dat, r_rd_data, w_rd_data;
    logic [c_tw-1:0]          r_timer, w_timer;
    logic [c_gw-1:0]          r_gap, w_gap;
    logic [LW-1:0]            r_cnt, w_cnt;
    logic [7:0]               r_bus, w_bus, r_cache_bus, w_cache_bus;
    logic [6:0]               r_addr, w_addr;
    logic                     r_rd, w_rd, r_cache_vld, w_cache_vld;
    logic [2:0]               r_result, w_result, r_status, w_status;
    logic                     r_xfer, w_xfer, r_reinit, w_reinit;

    // one-shot bus access request raised by the sequencing states
    logic                     w_go, w_go_we, w_poll, w_tmo_hit, w_poll_now;
    logic [WB_ADDR_WIDTH-1:0] w_go_adr;
    logic [WB_DATA_WIDTH-1:0] w_go_dat;
    state_t                   w_go_ret;
    logic                     w_unused_irq;

`ifdef IRQ_WAIT_EN
    assign w_poll_now   = irq_i;
    assign w_unused_irq = 1'b0;
`else
    assign w_poll_now   = (r_gap >= c_gap_last);
    assign w_unused_irq = irq_i;
`endif

    always_comb begin
        w_state = r_state;   w_ret = r_ret;     w_cont = r_cont;
        w_we = r_we;         w_adr = r_adr;     w_dat = r_dat;
        w_rd_data = r_rd_data; w_timer = r_timer; w_gap = r_gap;
        w_cnt = r_cnt;       w_bus = r_bus;     w_addr = r_addr;   w_rd = r_rd;
        w_cache_bus = r_cache_bus; w_cache_vld = r_cache_vld;
        w_result = r_result; w_status = r_status;
        w_xfer = r_xfer;     w_reinit = r_reinit;
        w_go = 1'b0; w_go_we = 1'b1; w_go_adr = '0; w_go_dat = '0;
        w_go_ret = r_state; w_poll = 1'b0; w_tmo_hit = 1'b0;

        if (r_state == S_BUS || r_state == S_GAP || r_state == S_WAIT || r_state == S_EVAL)
            w_timer = r_timer + c_tw'(1);

        case (r_state)
            S_INIT: begin
                w_cache_vld = 1'b0;
                w_go = 1'b1; w_go_adr = c_adr_csr; w_go_dat = c_csr_en; w_go_ret = S_IDLE;
            end
            S_IDLE: begin
                w_xfer = 1'b0;
                if (req_valid_i) begin
                    w_bus = req_bus_i; w_addr = req_addr_i; w_rd = req_rd_i;
                    w_cnt = req_len_i; w_xfer = 1'b1; w_result = c_st_ok;
                    if ({1'b0, req_bus_i} >= c_nbus) begin
                        w_result = c_st_err;
                        w_state  = S_DONE;
                    end else if (r_cache_vld && req_bus_i == r_cache_bus) begin
                        w_state = S_START;
                    end else begin
                        w_state = S_SETBUS;
                    end
                end
            end
            S_SETBUS: begin
                w_go = 1'b1; w_go_adr = c_adr_dpr; w_go_dat = WB_DATA_WIDTH'(r_bus);
                w_go_ret = S_SETBUS_CMD;
            end
            S_SETBUS_CMD: begin
                w_go = 1'b1; w_go_adr = c_adr_cmdr; w_go_dat = WB_DATA_WIDTH'(8'h06);
                w_go_ret = S_WAIT; w_cont = S_SETBUS_OK;
            end
            S_SETBUS_OK: begin
                w_cache_bus = r_bus; w_cache_vld = 1'b1; w_state = S_START;
            end
            S_START: begin
                w_go = 1'b1; w_go_adr = c_adr_cmdr; w_go_dat = WB_DATA_WIDTH'(8'h04);
                w_go_ret = S_WAIT; w_cont = S_ADDR;
            end
            S_ADDR: begin
                w_go = 1'b1; w_go_adr = c_adr_dpr; w_go_dat = WB_DATA_WIDTH'({r_addr, r_rd});
                w_go_ret = S_ADDR_CMD;
            end
            S_ADDR_CMD: begin
                w_go = 1'b1; w_go_adr = c_adr_cmdr; w_go_dat = WB_DATA_WIDTH'(8'h01);
                w_go_ret = S_WAIT; w_cont = S_XFER;
            end
            S_XFER: begin
                if (r_cnt == '0)  w_state = S_STOP;
                else if (r_rd)    w_state = S_RD_CMD;
                else              w_state = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (wdata_valid_i) begin
                    w_go = 1'b1; w_go_adr = c_adr_dpr; w_go_dat = WB_DATA_WIDTH'(wdata_i);
                    w_go_ret = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                w_go = 1'b1; w_go_adr = c_adr_cmdr; w_go_dat = WB_DATA_WIDTH'(8'h01);
                w_go_ret = S_WAIT; w_cont = S_XFER; w_cnt = r_cnt - LW'(1);
            end
            S_RD_CMD: begin
                w_go = 1'b1; w_go_adr = c_adr_cmdr;
                w_go_dat = (r_cnt == LW'(1)) ? WB_DATA_WIDTH'(8'h03) : WB_DATA_WIDTH'(8'h02);
                w_go_ret = S_WAIT; w_cont = S_RD_DPR; w_cnt = r_cnt - LW'(1);
            end
            S_RD_DPR: begin
                w_go = 1'b1; w_go_we = 1'b0; w_go_adr = c_adr_dpr; w_go_ret = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (rdata_ready_i) w_state = S_XFER;
            end
            S_STOP: begin
                w_go = 1'b1; w_go_adr = c_adr_cmdr; w_go_dat = WB_DATA_WIDTH'(8'h05);
                w_go_ret = S_WAIT; w_cont = S_DONE;
            end
            S_BUS: begin
                if (r_timer >= c_tmo) begin
                    w_tmo_hit = 1'b1;
                end else if (ack_i) begin
                    if (!r_we) w_rd_data = dat_i;
                    w_state = S_GAP;
                end
            end
            S_GAP: w_state = r_ret;
            S_WAIT: begin
                if (r_timer >= c_tmo) begin
                    w_tmo_hit = 1'b1;
                end else if (w_poll_now) begin
                    w_go = 1'b1; w_go_we = 1'b0; w_go_adr = c_adr_cmdr;
                    w_go_ret = S_EVAL; w_poll = 1'b1;
                end else begin
                    w_gap = r_gap + c_gw'(1);
                end
            end
            S_EVAL: begin
                // a NAK seen while already stopping must not loop back into STOP
                if (r_rd_data[7]) begin
                    w_state = r_cont;
                end else if (r_rd_data[6]) begin
                    if (r_result == c_st_ok) w_result = c_st_nak;
                    w_state = (r_cont == S_DONE) ? S_DONE : S_STOP;
                end else if (r_rd_data[5]) begin
                    w_result = c_st_al; w_cache_vld = 1'b0; w_state = S_DONE;
                end else if (r_rd_data[4]) begin
                    w_result = c_st_err; w_cache_vld = 1'b0; w_state = S_DONE;
                end else begin
                    w_state = S_WAIT;
                end
            end
            S_DONE: begin
                w_state  = r_reinit ? S_INIT : S_IDLE;
                w_reinit = 1'b0;
                w_xfer   = 1'b0;
            end
            default: w_state = S_INIT;
        endcase

        if (w_go) begin
            w_state = S_BUS; w_we = w_go_we; w_adr = w_go_adr; w_dat = w_go_dat;
            w_ret = w_go_ret; w_gap = '0;
            if (!w_poll) w_timer = '0;
        end

        if (w_tmo_hit) begin
            w_result = c_st_tmo; w_cache_vld = 1'b0; w_reinit = 1'b1;
            w_state  = r_xfer ? S_DONE : S_INIT;
        end

        if (w_state == S_DONE && r_state != S_DONE)
            w_status = w_result;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_INIT;  r_ret <= S_INIT;  r_cont <= S_INIT;
            r_we <= 1'b0;  r_adr <= '0;  r_dat <= '0;  r_rd_data <= '0;
            r_timer <= '0; r_gap <= '0;  r_cnt <= '0;
            r_bus <= '0;   r_addr <= '0; r_rd <= 1'b0;
            r_cache_bus <= '0; r_cache_vld <= 1'b0;
            r_result <= c_st_ok; r_status <= c_st_ok;
            r_xfer <= 1'b0; r_reinit <= 1'b0;
        end else begin
            r_state <= w_state;  r_ret <= w_ret;  r_cont <= w_cont;
            r_we <= w_we;  r_adr <= w_adr;  r_dat <= w_dat;  r_rd_data <= w_rd_data;
            r_timer <= w_timer; r_gap <= w_gap; r_cnt <= w_cnt;
            r_bus <= w_bus;  r_addr <= w_addr;  r_rd <= w_rd;
            r_cache_bus <= w_cache_bus; r_cache_vld <= w_cache_vld;
            r_result <= w_result; r_status <= w_status;
            r_xfer <= w_xfer; r_reinit <= w_reinit;
        end
    end

    assign req_ready_o   = (r_state == S_IDLE);
    assign cyc_o         = (r_state == S_BUS);
    assign stb_o         = cyc_o;
    assign we_o          = cyc_o & r_we;
    assign adr_o         = cyc_o ? r_adr : '0;
    assign dat_o         = we_o ? r_dat : '0;
    assign done_o        = (r_state == S_DONE);
    assign status_o      = r_status;
    assign wdata_ready_o = (r_state == S_WR_DATA);
    assign rdata_valid_o = (r_state == S_RD_OUT);
    assign rdata_o       = rdata_valid_o ? r_rd_data[7:0] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_i2cmb_xfer_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2cmb_xfer_engine
//  Purpose  : Directed scoreboard bench for i2cmb_xfer_engine with a simple
//             IICMB Wishbone slave model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2cmb_xfer_engine;

    localparam int LW = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_rd = 1'b0;
    logic [7:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic       wdata_valid = 1'b0, rdata_ready = 1'b1;
    logic [7:0] wdata = '0;
    logic       req_ready_o, wdata_ready_o, rdata_valid_o, done_o;
    logic [7:0] rdata_o;
    logic [2:0] status_o;
    logic       cyc_o, stb_o, we_o, ack_i;
    logic [1:0] adr_o;
    logic [7:0] dat_o, dat_i;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_wb[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd_q[$];
    logic [7:0] wq[$];
    logic [7:0] rd_head = 8'hEE, last_cmd = 8'h00, cmdr_resp;
    logic       nak_mode = 1'b0, never_done = 1'b0, rd_adv = 1'b0, wr_hs = 1'b0;
    int         cyc_cnt = 0;

    i2cmb_xfer_engine #(.TIMEOUT_CYC(200)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_rd_i(req_rd), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready), .rdata_o(rdata_o),
        .done_o(done_o), .status_o(status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(1'b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // slave: one-cycle ack, CMDR reads report the status of the last command
    always_comb begin
        cmdr_resp = never_done ? 8'h00 : ((nak_mode && last_cmd == 8'h01) ? 8'h40 : 8'h80);
    end
    assign dat_i = (adr_o == 2'd2) ? cmdr_resp : rd_head;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_i <= 1'b0;
        else        ack_i <= cyc_o && stb_o && !ack_i;
    end

    always @(negedge clk) begin
        logic [9:0] e;
        logic [7:0] r;
        if (rd_adv) begin
            rd_adv  = 1'b0;
            rd_head = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
        end
        if (cyc_o) cyc_cnt++;
        if (cyc_o && stb_o && ack_i) begin
            if (we_o) begin
                if (adr_o == 2'd2) last_cmd = dat_o;
                if (exp_wb.size() == 0) begin
                    check("wb_extra_write", {22'd0, adr_o, dat_o}, 32'h3FF);
                end else begin
                    e = exp_wb.pop_front();
                    check("wb_write", {22'd0, adr_o, dat_o}, {22'd0, e});
                end
            end else if (adr_o == 2'd1) begin
                rd_adv = 1'b1;
            end
        end
        if (rdata_valid_o && rdata_ready) begin
            if (exp_rd.size() == 0) begin
                check("rd_extra_byte", {24'd0, rdata_o}, 32'h1FF);
            end else begin
                r = exp_rd.pop_front();
                check("rd_byte", {24'd0, rdata_o}, {24'd0, r});
            end
        end
        // write-byte source: a byte offered with ready high is taken at the next edge
        if (wr_hs) void'(wq.pop_front());
        wdata_valid = (wq.size() > 0);
        wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
        wr_hs       = wdata_valid && wdata_ready_o;
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready_o && n < 500) begin @(negedge clk); n++; end
        check(tag, {31'd0, req_ready_o}, 32'd1);
    endtask

    task automatic send_req(input logic [7:0] bus, input logic [6:0] addr,
                            input logic rd, input logic [LW-1:0] len);
        wait_ready("req_ready");
        req_bus = bus; req_addr = addr; req_rd = rd; req_len = len; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input logic [2:0] exp_st);
        int n = 0;
        while (!done_o && n < budget) begin @(negedge clk); n++; end
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check({tag, "_status"}, {29'd0, status_o}, {29'd0, exp_st});
        @(negedge clk);
        check({tag, "_status_held"}, {29'd0, status_o}, {29'd0, exp_st});
    endtask

    function automatic logic [9:0] wr(input logic [1:0] a, input logic [7:0] d);
        return {a, d};
    endfunction

    function automatic logic [27:0] all_outs();
        return {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready_o, wdata_ready_o,
                rdata_valid_o, rdata_o, done_o, status_o};
    endfunction

    initial begin
        int n;
        int cyc_before;
        // reset and INIT
        repeat (3) @(negedge clk);
        check("reset_outputs", {4'd0, all_outs()}, 32'd0);
        exp_wb.push_back(wr(2'd0, 8'h80));
        rst_n = 1'b1;
        wait_ready("init_ready");
        check("init_writes_left", exp_wb.size(), 0);

        // write bus 3, addr 0x22, two bytes
        exp_wb = '{wr(1,8'h03), wr(2,8'h06), wr(2,8'h04), wr(1,8'h44), wr(2,8'h01),
                   wr(1,8'hA5), wr(2,8'h01), wr(1,8'h5A), wr(2,8'h01), wr(2,8'h05)};
        wq = '{8'hA5, 8'h5A};
        send_req(8'd3, 7'h22, 1'b0, 6'd2);
        wait_done("write", 2000, 3'd0);
        check("write_left", exp_wb.size(), 0);
        check("write_bytes_used", wq.size(), 0);

        // read again on cached bus 3: no bus select
        exp_wb = '{wr(2,8'h04), wr(1,8'h45), wr(2,8'h01), wr(2,8'h02), wr(2,8'h02),
                   wr(2,8'h03), wr(2,8'h05)};
        rd_head = 8'h11; rd_q = '{8'h22, 8'h33};
        exp_rd = '{8'h11, 8'h22, 8'h33};
        send_req(8'd3, 7'h22, 1'b1, 6'd3);
        wait_done("read", 2000, 3'd0);
        check("read_left", exp_wb.size(), 0);
        check("read_bytes_left", exp_rd.size(), 0);

        // address NAK: stop still issued, no data phase
        nak_mode = 1'b1;
        exp_wb = '{wr(2,8'h04), wr(1,8'hA0), wr(2,8'h01), wr(2,8'h05)};
        send_req(8'd3, 7'h50, 1'b0, 6'd2);
        wait_done("nak", 2000, 3'd1);
        check("nak_left", exp_wb.size(), 0);
        nak_mode = 1'b0;

        // illegal bus index: error with no Wishbone traffic
        cyc_before = cyc_cnt;
        send_req(8'd16, 7'h22, 1'b0, 6'd1);
        wait_done("badbus", 10, 3'd3);
        check("badbus_no_cyc", cyc_cnt - cyc_before, 0);

        // zero-length probe on a new bus
        exp_wb = '{wr(1,8'h05), wr(2,8'h06), wr(2,8'h04), wr(1,8'h20), wr(2,8'h01), wr(2,8'h05)};
        send_req(8'd5, 7'h10, 1'b0, 6'd0);
        wait_done("probe", 2000, 3'd0);
        check("probe_left", exp_wb.size(), 0);

        // command never completes: timeout, then controller re-enabled
        never_done = 1'b1;
        exp_wb = '{wr(2,8'h04), wr(0,8'h80)};
        send_req(8'd5, 7'h10, 1'b1, 6'd1);
        wait_done("timeout", 1000, 3'd4);
        never_done = 1'b0;
        wait_ready("timeout_ready");
        check("timeout_left", exp_wb.size(), 0);

        // reset while a read byte is stalled
        rdata_ready = 1'b0;
        exp_wb = '{wr(1,8'h05), wr(2,8'h06), wr(2,8'h04), wr(1,8'h21), wr(2,8'h01), wr(2,8'h02)};
        rd_head = 8'h77; rd_q = '{8'h88};
        send_req(8'd5, 7'h10, 1'b1, 6'd2);
        n = 0;
        while (!rdata_valid_o && n < 2000) begin @(negedge clk); n++; end
        check("stall_valid", {31'd0, rdata_valid_o}, 32'd1);
        check("stall_byte", {24'd0, rdata_o}, 32'h77);
        check("stall_left", exp_wb.size(), 0);
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs", {4'd0, all_outs()}, 32'd0);
        exp_wb.delete();
        exp_wb.push_back(wr(2'd0, 8'h80));
        rd_q.delete();
        rdata_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("rerun_ready");
        check("rerun_init_left", exp_wb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
